sc_match_arbiter: RTL and testbench
===================================

// Module: sc_match_arbiter
// PURPOSE
//  Round-robin arbiter sharing the single scoring datapath among the 37 note-buffer slots.
//  Every match_trigger pulse is latched with its timing error. The error is |song_time - match_time|, taken at trigger time.
//  Latched matches are then granted one per cycle over a valid/ready handshake to the scorer.
//  Simultaneous hits are no longer lost, and timing error is not skewed by queue delay.
// PARAMETERS
//  N_SLOTS  37  number of note-buffer slots (requesters)
//  TIME_W   16  width of song_time / match_time / match_dt
//  IDX_W    6   width of slot index, $clog2(N_SLOTS)
// PORTS
//  clk            in   1               system clock
//  reset          in   1               synchronous, active-high reset
//  flush          in   1               song restart: drop all pending and offered matches
//  song_time      in   TIME_W          current song time
//  match_trigger  in   N_SLOTS         per-slot 1-cycle hit pulse
//  match_time     in   N_SLOTS*TIME_W  per-slot note time; slot i = bits [i*TIME_W +: TIME_W]
//  out_valid      out  1               match offered to scorer
//  out_ready      in   1               scorer accepts offered match
//  match_dt       out  TIME_W          abs timing error of offered match
//  match_slot     out  IDX_W           slot index of offered match
//  drop_pulse     out  1               1-cycle: a trigger collided with a pending match on that slot
// BEHAVIOUR
//  Reset / flush
//   - reset or flush (same cycle): pending=0, dt regs=0, rr_ptr=0, state=IDLE.
//   - Outputs: out_valid=0, match_dt=0, match_slot=0, drop_pulse=0.
//   - flush has no priority over reset; both clear identically.
//   - Triggers in a reset/flush cycle are discarded.
//  Capture
//   - Per slot i, on match_trigger[i]=1:
//     dt_i <= (song_time >= t_i) ? song_time - t_i : t_i - song_time   (unsigned, TIME_W, no wrap handling)
//     pending[i] <= 1
//  Collision
//   - Trigger on a slot whose pending=1 and is not being granted this cycle:
//     keep the older dt, ignore the new one, drop_pulse=1 next cycle.
//   - Trigger on a slot being granted this cycle: the set wins. New dt is captured, pending stays 1, no drop.
//  Grant pick
//   - First pending slot at or after rr_ptr, searching upward and wrapping N_SLOTS-1 -> 0.
//   - On grant: rr_ptr <= (slot==N_SLOTS-1) ? 0 : slot+1.
//  FSM
//   - IDLE: out_valid=0. If any pending: load match_dt/match_slot from pick, clear pending[pick], go OFFER.
//   - OFFER: out_valid=1, match_dt/match_slot held stable while out_ready=0.
//   - OFFER with out_ready=1 and any pending: load next pick and stay in OFFER (back-to-back, 1 match/cycle).
//   - OFFER with out_ready=1 and nothing pending: go IDLE.
//  Latency
//   - Trigger at cycle t -> pending at t+1 -> out_valid earliest at t+2.
//   - Pending is the only buffering: capacity is 1 outstanding match per slot plus 1 in the output reg.
// CONFIGURATION
//  SC_ARB_DROP_COUNT_EN defined:
//   - Adds port drop_count (out, 16): saturating count of drop_pulse events.
//   - Cleared by reset and flush; holds at 16'hFFFF.
//  Undefined: no drop_count port or counter; drop_pulse still present.
// STRUCTURE
//  Package sc_pkg:
//   - N_SLOTS, TIME_W, IDX_W constants
//   - arb_state_t enum {IDLE, OFFER}
//   - slot_idx_t typedef
//  Sub-module sc_rr_pick:
//   - Combinational, inputs pending[N_SLOTS] and rr_ptr.
//   - Outputs any and idx (round-robin first-set search).
// TESTING
//  1. Reset: hold reset 3 cycles with triggers active -> out_valid=0, match_dt=0, match_slot=0, drop_pulse=0, pending=0.
//  2. Single hit: song_time=1000, slot 5 time=990, trigger[5] at t, ready=1 -> t+2: valid, slot=5, dt=10. t+3: valid=0.
//  3. Simultaneous: slots 0, 17, 36 trigger at once, rr_ptr=0, ready=1
//     -> 3 consecutive grants in order 0, 17, 36. rr_ptr=0 afterward (wrap).
//  4. Backpressure: as in 3 with ready=0 for 4 cycles
//     -> slot 0 held stable, valid=1. Then 0, 17, 36 back-to-back once ready=1.
//  5. Collision: trigger[3] at song_time=500 (time 490), trigger[3] again at 520 while still pending
//     -> drop_pulse=1 once, granted dt=10.
//     With SC_ARB_DROP_COUNT_EN defined: drop_count=1.
//  6. Flush: flush in the OFFER state with 2 pending -> next cycle valid=0, pending=0, rr_ptr=0.
//     Trigger at song_time=10 with time=40 -> dt=30.

Source files
------------

// File: rtl/sc_pkg.sv
// Shared constants and types for the note-match arbitration slice.
package sc_pkg;

    localparam int N_SLOTS = 37;
    localparam int TIME_W  = 16;
    localparam int IDX_W   = 6;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } arb_state_t;

    typedef logic [IDX_W-1:0] slot_idx_t;

    // Unsigned absolute difference; song time is assumed never to wrap.
    function automatic logic [TIME_W-1:0] abs_diff(input logic [TIME_W-1:0] a,
                                                   input logic [TIME_W-1:0] b);
        logic [TIME_W-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

endpackage

// File: rtl/sc_rr_pick.sv
// Round-robin first-set search: the first pending slot at or after rr_ptr,
// wrapping from N_SLOTS-1 back to slot 0.
module sc_rr_pick
    import sc_pkg::*;
(
    input  logic [N_SLOTS-1:0] pending,
    input  slot_idx_t          rr_ptr,
    output logic               any,
    output slot_idx_t          idx
);

    int        pos_s;
    slot_idx_t cand_s;

    // Scan offsets from farthest to nearest so the nearest hit is the final assignment.
    always_comb begin
        any    = 1'b0;
        idx    = '0;
        pos_s  = 0;
        cand_s = '0;
        for (int k = N_SLOTS - 1; k >= 0; k--) begin
            pos_s = int'(rr_ptr) + k;
            if (pos_s >= N_SLOTS) begin
                pos_s = pos_s - N_SLOTS;
            end else begin
                pos_s = pos_s;
            end
            cand_s = IDX_W'(pos_s);
            if (pending[cand_s]) begin
                any = 1'b1;
                idx = cand_s;
            end else begin
                any = any;
            end
        end
    end

endmodule

// File: rtl/sc_match_arbiter.sv
// Latches per-slot match hits with their timing error and hands them to the
// single scorer one per cycle over valid/ready, in round-robin order.
// Optional macro SC_ARB_DROP_COUNT_EN adds a saturating drop_count output.
module sc_match_arbiter
    import sc_pkg::*;
(
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      flush,
    input  logic [TIME_W-1:0]         song_time,
    input  logic [N_SLOTS-1:0]        match_trigger,
    input  logic [N_SLOTS*TIME_W-1:0] match_time,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [TIME_W-1:0]         match_dt,
    output slot_idx_t                 match_slot,
    output logic                      drop_pulse
`ifdef SC_ARB_DROP_COUNT_EN
    ,
    output logic [15:0]               drop_count
`endif
);

    arb_state_t         state_r, state_nxt_s;
    logic [N_SLOTS-1:0] pending_r, pending_nxt_s;
    logic [N_SLOTS-1:0] capture_s, collide_s;
    logic [TIME_W-1:0]  dt_r     [N_SLOTS];
    logic [TIME_W-1:0]  new_dt_s [N_SLOTS];
    slot_idx_t          rr_ptr_r;
    logic               pick_any_s;
    slot_idx_t          pick_idx_s;
    logic               grant_s;
    logic [TIME_W-1:0]  match_dt_r;
    slot_idx_t          match_slot_r;
    logic               drop_pulse_r;
    logic               clear_s;

    assign clear_s = reset | flush;

    sc_rr_pick u_pick (
        .pending (pending_r),
        .rr_ptr  (rr_ptr_r),
        .any     (pick_any_s),
        .idx     (pick_idx_s)
    );

    // Next-state and grant decision: a grant happens whenever the output register is free or being drained.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        case (state_r)
            IDLE: begin
                if (pick_any_s) begin
                    grant_s     = 1'b1;
                    state_nxt_s = OFFER;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            OFFER: begin
                if (out_ready) begin
                    if (pick_any_s) begin
                        grant_s     = 1'b1;
                        state_nxt_s = OFFER;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = OFFER;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Per-slot capture: a new hit on a slot being granted this cycle replaces it; otherwise an older pending hit wins.
    always_comb begin
        pending_nxt_s = pending_r;
        capture_s     = '0;
        collide_s     = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            new_dt_s[i] = abs_diff(song_time, match_time[i*TIME_W +: TIME_W]);
            if (match_trigger[i] && pending_r[i] &&
                !(grant_s && (pick_idx_s == IDX_W'(i)))) begin
                collide_s[i] = 1'b1;
            end else begin
                collide_s[i] = 1'b0;
            end
            capture_s[i] = match_trigger[i] & ~collide_s[i];
            if (capture_s[i]) begin
                pending_nxt_s[i] = 1'b1;
            end else if (grant_s && (pick_idx_s == IDX_W'(i))) begin
                pending_nxt_s[i] = 1'b0;
            end else begin
                pending_nxt_s[i] = pending_r[i];
            end
        end
    end

    // Pending flags and latched timing errors.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            pending_r <= '0;
            for (int i = 0; i < N_SLOTS; i++) begin
                dt_r[i] <= '0;
            end
        end else begin
            pending_r <= pending_nxt_s;
            for (int i = 0; i < N_SLOTS; i++) begin
                if (capture_s[i]) begin
                    dt_r[i] <= new_dt_s[i];
                end else begin
                    dt_r[i] <= dt_r[i];
                end
            end
        end
    end

    // FSM state, round-robin pointer and registered outputs.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            state_r      <= IDLE;
            rr_ptr_r     <= '0;
            match_dt_r   <= '0;
            match_slot_r <= '0;
            drop_pulse_r <= 1'b0;
        end else begin
            state_r      <= state_nxt_s;
            drop_pulse_r <= |collide_s;
            if (grant_s) begin
                match_dt_r   <= dt_r[pick_idx_s];
                match_slot_r <= pick_idx_s;
                if (pick_idx_s == IDX_W'(N_SLOTS - 1)) begin
                    rr_ptr_r <= '0;
                end else begin
                    rr_ptr_r <= pick_idx_s + 6'd1;
                end
            end else begin
                match_dt_r   <= match_dt_r;
                match_slot_r <= match_slot_r;
                rr_ptr_r     <= rr_ptr_r;
            end
        end
    end

    assign out_valid  = (state_r == OFFER);
    assign match_dt   = match_dt_r;
    assign match_slot = match_slot_r;
    assign drop_pulse = drop_pulse_r;

`ifdef SC_ARB_DROP_COUNT_EN
    logic [15:0] drop_cnt_r;

    // Saturating count of collision drops.
    always_ff @(posedge clk) begin
        if (clear_s) begin
            drop_cnt_r <= 16'h0000;
        end else if (drop_pulse_r && (drop_cnt_r != 16'hFFFF)) begin
            drop_cnt_r <= drop_cnt_r + 16'h0001;
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign drop_count = drop_cnt_r;
`endif

endmodule

// File: tb/tb_sc_match_arbiter.sv
// Directed bench for sc_match_arbiter with hand-computed expectations.
module tb_sc_match_arbiter;
    import sc_pkg::*;

    logic                      clk;
    logic                      reset;
    logic                      flush;
    logic [TIME_W-1:0]         song_time;
    logic [N_SLOTS-1:0]        match_trigger;
    logic [N_SLOTS*TIME_W-1:0] match_time;
    logic                      out_valid;
    logic                      out_ready;
    logic [TIME_W-1:0]         match_dt;
    slot_idx_t                 match_slot;
    logic                      drop_pulse;
`ifdef SC_ARB_DROP_COUNT_EN
    logic [15:0]               drop_count;
`endif

    int n_checks;
    int n_fail;

    sc_match_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .song_time     (song_time),
        .match_trigger (match_trigger),
        .match_time    (match_time),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .match_dt      (match_dt),
        .match_slot    (match_slot),
        .drop_pulse    (drop_pulse)
`ifdef SC_ARB_DROP_COUNT_EN
        ,
        .drop_count    (drop_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; inputs are driven and outputs sampled 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_time(input int slot, input logic [TIME_W-1:0] t);
        match_time[slot*TIME_W +: TIME_W] = t;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic expect_offer(input string tag, input int slot, input int dt);
        check_val({tag, "_valid"}, 64'(out_valid), 64'd1);
        check_val({tag, "_slot"}, 64'(match_slot), 64'(slot));
        check_val({tag, "_dt"}, 64'(match_dt), 64'(dt));
    endtask

    // Load slots 0, 17, 36 with distinct timing errors 100, 17, 36 at song_time 1000.
    task automatic trig_three();
        song_time = 16'd1000;
        set_time(0, 16'd1100);
        set_time(17, 16'd983);
        set_time(36, 16'd1036);
        match_trigger = '0;
        match_trigger[0]  = 1'b1;
        match_trigger[17] = 1'b1;
        match_trigger[36] = 1'b1;
        tick();
        match_trigger = '0;
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        reset         = 1'b0;
        flush         = 1'b0;
        song_time     = '0;
        match_trigger = '0;
        match_time    = '0;
        out_ready     = 1'b1;
        #2;

        // 1. Reset held 3 cycles with all triggers active.
        reset = 1'b1;
        match_trigger = '1;
        song_time = 16'd77;
        repeat (3) tick();
        reset = 1'b0;
        match_trigger = '0;
        check_val("rst_valid", 64'(out_valid), 64'd0);
        check_val("rst_dt", 64'(match_dt), 64'd0);
        check_val("rst_slot", 64'(match_slot), 64'd0);
        check_val("rst_drop", 64'(drop_pulse), 64'd0);
        check_val("rst_pending", 64'(dut.pending_r), 64'd0);
        tick();
        check_val("rst_idle", 64'(out_valid), 64'd0);

        // 2. Single hit on slot 5.
        do_reset();
        song_time = 16'd1000;
        set_time(5, 16'd990);
        match_trigger[5] = 1'b1;
        tick();
        match_trigger = '0;
        check_val("single_t1_valid", 64'(out_valid), 64'd0);
        tick();
        expect_offer("single", 5, 10);
        tick();
        check_val("single_t3_valid", 64'(out_valid), 64'd0);

        // 3. Simultaneous hits, ready held high.
        do_reset();
        out_ready = 1'b1;
        trig_three();
        tick();
        expect_offer("simul_0", 0, 100);
        tick();
        expect_offer("simul_17", 17, 17);
        tick();
        expect_offer("simul_36", 36, 36);
        tick();
        check_val("simul_end_valid", 64'(out_valid), 64'd0);
        check_val("simul_rr_wrap", 64'(dut.rr_ptr_r), 64'd0);

        // 4. Backpressure for 4 cycles.
        do_reset();
        out_ready = 1'b0;
        trig_three();
        for (int c = 0; c < 4; c++) begin
            tick();
            expect_offer("bp_hold", 0, 100);
        end
        out_ready = 1'b1;
        tick();
        expect_offer("bp_17", 17, 17);
        tick();
        expect_offer("bp_36", 36, 36);
        tick();
        check_val("bp_end_valid", 64'(out_valid), 64'd0);

        // 5. Collision: slot 1 occupies the output, slot 3 hit twice while pending.
        do_reset();
        out_ready = 1'b0;
        song_time = 16'd500;
        set_time(1, 16'd500);
        match_trigger[1] = 1'b1;
        tick();
        match_trigger = '0;
        tick();
        expect_offer("coll_hold1", 1, 0);
        set_time(3, 16'd490);
        match_trigger[3] = 1'b1;
        tick();
        check_val("coll_nodrop_first", 64'(drop_pulse), 64'd0);
        song_time = 16'd520;
        tick();
        match_trigger = '0;
        check_val("coll_drop", 64'(drop_pulse), 64'd1);
        tick();
        check_val("coll_drop_once", 64'(drop_pulse), 64'd0);
        out_ready = 1'b1;
        tick();
        expect_offer("coll_grant3", 3, 10);
`ifdef SC_ARB_DROP_COUNT_EN
        check_val("coll_drop_count", 64'(drop_count), 64'd1);
`endif
        tick();
        check_val("coll_end_valid", 64'(out_valid), 64'd0);

        // 5b. Re-hit on a slot being granted this cycle: new dt replaces, no drop.
        do_reset();
        out_ready = 1'b1;
        song_time = 16'd100;
        set_time(8, 16'd90);
        match_trigger[8] = 1'b1;
        tick();
        song_time = 16'd130;
        tick();
        match_trigger = '0;
        expect_offer("setwin_first", 8, 10);
        check_val("setwin_nodrop", 64'(drop_pulse), 64'd0);
        tick();
        expect_offer("setwin_second", 8, 40);
        tick();
        check_val("setwin_end_valid", 64'(out_valid), 64'd0);

        // 6. Flush while offering with two pending.
        do_reset();
        out_ready = 1'b0;
        trig_three();
        tick();
        expect_offer("flush_pre", 0, 100);
        flush = 1'b1;
        match_trigger[20] = 1'b1;
        tick();
        flush = 1'b0;
        match_trigger = '0;
        check_val("flush_valid", 64'(out_valid), 64'd0);
        check_val("flush_pending", 64'(dut.pending_r), 64'd0);
        check_val("flush_rr", 64'(dut.rr_ptr_r), 64'd0);
        check_val("flush_dt", 64'(match_dt), 64'd0);
        check_val("flush_slot", 64'(match_slot), 64'd0);
        out_ready = 1'b1;
        song_time = 16'd10;
        set_time(2, 16'd40);
        match_trigger[2] = 1'b1;
        tick();
        match_trigger = '0;
        tick();
        expect_offer("flush_after", 2, 30);
        tick();
        check_val("flush_end_valid", 64'(out_valid), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
